// File: rtl/byte_stripe_pkg.sv
// byte_stripe_pkg: shared definitions for the byte-striping scheduler.
//   - K-symbol byte codes used on the lane stream
//   - scheduler state enum
//   - lane_w(): width of the lane-select field for a given lane count
package byte_stripe_pkg;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_IDL = 8'h7C;
  localparam logic [7:0] K_PAD = 8'hF7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAD  = 2'd2,
    SKIP = 2'd3
  } state_t;

  // A single-lane build still carries a 1-bit (always zero) lane select.
  function automatic int lane_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/byte_stripe_if.sv
// byte_stripe_if: framed-byte input handshake plus lane-sequenced output.
//   IN_VALID/IN_D/IN_DK  framed byte offered by the framer
//   IN_READY             scheduler takes the byte this cycle
//   OUT_VALID/OUT_D/OUT_DK byte for lane LANE_SEL
//   LANE_SEL             destination lane of the current output byte
//   SYM_DONE             high on the last lane of each symbol time
//   ERR                  one-cycle framing-error pulse
// Modports: master = framer/consumer side, slave = scheduler.
interface byte_stripe_if
  import byte_stripe_pkg::*;
#(
  parameter int LANES = 4
) ();
  localparam int LW = lane_w(LANES);

  logic          IN_VALID;
  logic [7:0]    IN_D;
  logic          IN_DK;
  logic          IN_READY;
  logic          OUT_VALID;
  logic [7:0]    OUT_D;
  logic          OUT_DK;
  logic [LW-1:0] LANE_SEL;
  logic          SYM_DONE;
  logic          ERR;

  modport master (
    output IN_VALID, IN_D, IN_DK,
    input  IN_READY, OUT_VALID, OUT_D, OUT_DK, LANE_SEL, SYM_DONE, ERR
  );

  modport slave (
    input  IN_VALID, IN_D, IN_DK,
    output IN_READY, OUT_VALID, OUT_D, OUT_DK, LANE_SEL, SYM_DONE, ERR
  );

endinterface

// File: rtl/byte_stripe_skp_timer.sv
// byte_stripe_skp_timer: SKP ordered-set request timer.
//   clk, rst     clock, synchronous active-high reset
//   sym_done     one pulse per completed symbol time
//   serve        scheduler is starting a SKIP sequence this cycle
//   pending      registered request flag
//   pending_nxt  value pending takes at the next edge (lets the scheduler
//                register IN_READY one cycle ahead)
// Every SKP_INTERVAL symbol times the flag is set; a new expiry wins over a
// simultaneous serve, and an expiry while already pending is absorbed.
module byte_stripe_skp_timer #(
  parameter int SKP_INTERVAL = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sym_done,
  input  logic serve,
  output logic pending,
  output logic pending_nxt
);
  localparam int CW = $clog2(SKP_INTERVAL);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          expire;

  always_comb begin
    expire      = sym_done && (cnt == CW'(SKP_INTERVAL - 1));
    cnt_n       = cnt;
    if (sym_done) begin
      cnt_n = expire ? '0 : cnt + 1'b1;
    end
    pending_nxt = expire | (pending & ~serve);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      pending <= pending_nxt;
    end
  end

endmodule

// File: rtl/byte_stripe_sched.sv
// byte_stripe_sched: scheduler in front of the byte-striping datapath.
// Takes one framed byte per cycle and emits one byte per cycle to lane
// LANE_SEL: packets start on lane 0, tails are padded to the symbol-time
// boundary, gaps carry IDL, and (optionally) SKP ordered sets are inserted.
//   CLK, RESET  clock, synchronous active-high reset
//   bus         byte_stripe_if.slave (input handshake + lane output)
// Optional build macro BYTE_STRIPE_SKP_INSERT_EN: adds the SKP timer and
// SKIP state (COM symbol then three SKP symbols). Without it SKIP is never
// entered and SKP_INTERVAL has no effect.
module byte_stripe_sched
  import byte_stripe_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int SKP_INTERVAL = 16
) (
  input logic          CLK,
  input logic          RESET,
  byte_stripe_if.slave bus
);
  localparam int            LW        = lane_w(LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  if (LANES < 1 || LANES > 16 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
    $error("byte_stripe_sched: LANES must be a power of two in 1..16");
  end
  if (SKP_INTERVAL < 2) begin : g_bad_skp
    $error("byte_stripe_sched: SKP_INTERVAL must be at least 2");
  end

  state_t        state;
  state_t        state_n;
  state_t        tail_state;
  logic [LW-1:0] slot;
  logic          accept;
  logic          pending;
  logic          pending_nxt;
  logic [7:0]    d_n;
  logic          dk_n;
  logic          err_n;
  logic          in_ready_n;

  function automatic logic [LW-1:0] next_lane(input logic [LW-1:0] l);
    return (l == LAST_LANE) ? '0 : l + 1'b1;
  endfunction

`ifdef BYTE_STRIPE_SKP_INSERT_EN
  localparam int SKIP_LEN = 4 * LANES;
  localparam int SW       = $clog2(SKIP_LEN);

  logic [SW-1:0] skip_cnt;
  logic [SW-1:0] skip_cnt_n;
  logic          serve;

  // Request is cleared on the cycle the scheduler commits to SKIP.
  assign serve = (state_n == SKIP) && (state != SKIP);

  byte_stripe_skp_timer #(
    .SKP_INTERVAL(SKP_INTERVAL)
  ) u_skp_timer (
    .clk        (CLK),
    .rst        (RESET),
    .sym_done   (bus.SYM_DONE),
    .serve      (serve),
    .pending    (pending),
    .pending_nxt(pending_nxt)
  );

  assign tail_state = pending ? SKIP : IDLE;
`else
  assign pending     = 1'b0;
  assign pending_nxt = 1'b0;
  assign tail_state  = IDLE;
`endif

  // Lane of the byte produced at the coming edge; the first slot after reset
  // is lane 0.
  assign slot   = bus.OUT_VALID ? next_lane(bus.LANE_SEL) : '0;
  assign accept = bus.IN_VALID & bus.IN_READY;

  always_comb begin
    state_n = state;
    d_n     = K_IDL;
    dk_n    = 1'b1;
    err_n   = 1'b0;
`ifdef BYTE_STRIPE_SKP_INSERT_EN
    skip_cnt_n = skip_cnt;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.IN_DK && (bus.IN_D == K_STP || bus.IN_D == K_SDP)) begin
            d_n     = bus.IN_D;
            state_n = DATA;
          end else begin
            err_n = 1'b1;
          end
        end
`ifdef BYTE_STRIPE_SKP_INSERT_EN
        else if (pending && slot == '0) begin
          // First COM goes out now, so the SKIP counter starts at 1.
          d_n        = K_COM;
          state_n    = SKIP;
          skip_cnt_n = SW'(1);
        end
`endif
      end
      DATA: begin
        if (accept) begin
          d_n  = bus.IN_D;
          dk_n = bus.IN_DK;
          if (bus.IN_DK) begin
            if (bus.IN_D == K_END || bus.IN_D == K_EDB) begin
              state_n = (slot == LAST_LANE) ? tail_state : PAD;
            end else begin
              err_n = 1'b1;
            end
          end
        end else begin
          // Underrun: terminate the packet with EDB.
          d_n     = K_EDB;
          err_n   = 1'b1;
          state_n = (slot == LAST_LANE) ? tail_state : PAD;
        end
`ifdef BYTE_STRIPE_SKP_INSERT_EN
        skip_cnt_n = '0;
`endif
      end
      PAD: begin
        d_n = K_PAD;
        if (slot == LAST_LANE) begin
          state_n = tail_state;
        end
`ifdef BYTE_STRIPE_SKP_INSERT_EN
        skip_cnt_n = '0;
`endif
      end
`ifdef BYTE_STRIPE_SKP_INSERT_EN
      SKIP: begin
        d_n        = (skip_cnt < SW'(LANES)) ? K_COM : K_SKP;
        skip_cnt_n = skip_cnt + 1'b1;
        if (skip_cnt == SW'(SKIP_LEN - 1)) begin
          state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    // IN_READY is registered, so it is computed for the slot after this one.
    in_ready_n = (state_n == DATA) ||
                 (state_n == IDLE && next_lane(slot) == '0 && !pending_nxt);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      bus.OUT_VALID <= 1'b0;
      bus.OUT_D     <= '0;
      bus.OUT_DK    <= 1'b0;
      bus.LANE_SEL  <= '0;
      bus.SYM_DONE  <= 1'b0;
      bus.ERR       <= 1'b0;
      bus.IN_READY  <= 1'b0;
`ifdef BYTE_STRIPE_SKP_INSERT_EN
      skip_cnt      <= '0;
`endif
    end else begin
      state         <= state_n;
      bus.OUT_VALID <= 1'b1;
      bus.OUT_D     <= d_n;
      bus.OUT_DK    <= dk_n;
      bus.LANE_SEL  <= slot;
      bus.SYM_DONE  <= (slot == LAST_LANE);
      bus.ERR       <= err_n;
      bus.IN_READY  <= in_ready_n;
`ifdef BYTE_STRIPE_SKP_INSERT_EN
      skip_cnt      <= skip_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_byte_stripe_sched.sv
// tb_byte_stripe_sched: directed bench for byte_stripe_sched, LANES=4.
// With BYTE_STRIPE_SKP_INSERT_EN defined it exercises SKP insertion with
// SKP_INTERVAL=4; otherwise it exercises packet framing, padding and errors.
module tb_byte_stripe_sched;
  import byte_stripe_pkg::*;

  localparam int LANES        = 4;
  localparam int SKP_INTERVAL = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  byte_stripe_if #(.LANES(LANES)) bus ();

  byte_stripe_sched #(
    .LANES       (LANES),
    .SKP_INTERVAL(SKP_INTERVAL)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic k);
    bus.IN_VALID = v;
    bus.IN_D     = d;
    bus.IN_DK    = k;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed view {VALID, DK, D, LANE_SEL, SYM_DONE, ERR}; SYM_DONE expected on lane 3.
  task automatic chk_out(input string tag, input logic [7:0] d, input logic k,
                         input logic [1:0] lane, input logic e);
    chk(tag, {2'b00, bus.OUT_VALID, bus.OUT_DK, bus.OUT_D, bus.LANE_SEL, bus.SYM_DONE, bus.ERR},
             {2'b00, 1'b1, k, d, lane, (lane == 2'd3), e});
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {2'b00, bus.OUT_VALID, bus.OUT_DK, bus.OUT_D, bus.LANE_SEL, bus.SYM_DONE, bus.ERR},
             16'h0000);
    chk({tag, "_rdy"}, {15'd0, bus.IN_READY}, 16'h0000);
  endtask

  logic [7:0] pkt_d [7];
  logic       pkt_k [7];

  initial begin
    pkt_d = '{K_STP, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, K_END};
    pkt_k = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    step();
    step();
    chk_reset("reset");
    rst = 1'b0;

    // Idle stream: IDL on lanes 0,1,2,3,0; ready only ahead of lane 0.
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("idle%0d", i), K_IDL, 1'b1, 2'(i % 4), 1'b0);
      chk($sformatf("idle_rdy%0d", i), {15'd0, bus.IN_READY}, {15'd0, (i % 4) == 3});
    end

`ifndef BYTE_STRIPE_SKP_INSERT_EN
    // Packet STP,11..55,END from lane 0: END on lane 2, PAD on lane 3.
    step(); step(); step();
    chk("pkt_rdy", {15'd0, bus.IN_READY}, 16'd1);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, pkt_d[i], pkt_k[i]);
      step();
      chk_out($sformatf("pkt%0d", i), pkt_d[i], pkt_k[i], 2'(i % 4), 1'b0);
    end
    drive(1'b0, 8'h00, 1'b0);
    step();
    chk_out("pad", K_PAD, 1'b1, 2'd3, 1'b0);
    chk("pad_rdy", {15'd0, bus.IN_READY}, 16'd1);
    step();
    chk_out("idl_after_pad", K_IDL, 1'b1, 2'd0, 1'b0);

    // STP offered while lane 1 is showing: held until lane 0 slot.
    step();
    drive(1'b1, K_STP, 1'b1);
    chk("hold_rdy1", {15'd0, bus.IN_READY}, 16'd0);
    step();
    chk_out("hold_l2", K_IDL, 1'b1, 2'd2, 1'b0);
    chk("hold_rdy2", {15'd0, bus.IN_READY}, 16'd0);
    step();
    chk_out("hold_l3", K_IDL, 1'b1, 2'd3, 1'b0);
    chk("hold_rdy3", {15'd0, bus.IN_READY}, 16'd1);
    step();
    chk_out("stp_l0", K_STP, 1'b1, 2'd0, 1'b0);

    // Underrun after STP,AA: EDB on lane 2 with ERR, PAD on lane 3.
    drive(1'b1, 8'hAA, 1'b0);
    step();
    chk_out("aa_l1", 8'hAA, 1'b0, 2'd1, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    step();
    chk_out("edb_l2", K_EDB, 1'b1, 2'd2, 1'b1);
    step();
    chk_out("edb_pad", K_PAD, 1'b1, 2'd3, 1'b0);
    step();
    chk_out("edb_idle", K_IDL, 1'b1, 2'd0, 1'b0);

    // Non-STP byte accepted in IDLE: IDL plus ERR.
    step(); step(); step();
    drive(1'b1, 8'h42, 1'b0);
    step();
    chk_out("idle_err", K_IDL, 1'b1, 2'd0, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    step();
    chk_out("idle_err_clr", K_IDL, 1'b1, 2'd1, 1'b0);

    // Stray K symbol inside a packet: forwarded with ERR.
    step(); step();
    drive(1'b1, K_STP, 1'b1);
    step();
    chk_out("k_stp", K_STP, 1'b1, 2'd0, 1'b0);
    drive(1'b1, K_COM, 1'b1);
    step();
    chk_out("k_com", K_COM, 1'b1, 2'd1, 1'b1);
    drive(1'b1, K_END, 1'b1);
    step();
    chk_out("k_end", K_END, 1'b1, 2'd2, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    step();
    chk_out("k_pad", K_PAD, 1'b1, 2'd3, 1'b0);

    // END on the last lane: straight back to IDLE, no PAD.
    drive(1'b1, K_SDP, 1'b1);
    step();
    chk_out("l3_sdp", K_SDP, 1'b1, 2'd0, 1'b0);
    drive(1'b1, 8'h01, 1'b0);
    step();
    chk_out("l3_d1", 8'h01, 1'b0, 2'd1, 1'b0);
    drive(1'b1, 8'h02, 1'b0);
    step();
    chk_out("l3_d2", 8'h02, 1'b0, 2'd2, 1'b0);
    drive(1'b1, K_END, 1'b1);
    step();
    chk_out("l3_end", K_END, 1'b1, 2'd3, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    step();
    chk_out("l3_idle", K_IDL, 1'b1, 2'd0, 1'b0);
    chk("l3_idle_rdy", {15'd0, bus.IN_READY}, 16'd0);

    // Reset mid-packet: partial packet dropped, no terminator.
    step(); step(); step();
    drive(1'b1, K_STP, 1'b1);
    step();
    chk_out("rp_stp", K_STP, 1'b1, 2'd0, 1'b0);
    drive(1'b1, 8'h77, 1'b0);
    rst = 1'b1;
    step();
    chk_reset("rp_reset");
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    step();
    chk_out("rp_after", K_IDL, 1'b1, 2'd0, 1'b0);
`else
    // Idle stream continues; request raised after the 4th symbol is served
    // at the next lane-0 boundary.
    for (int i = 6; i <= 20; i++) begin
      step();
      chk_out($sformatf("sidle%0d", i), K_IDL, 1'b1, 2'((i - 1) % 4), 1'b0);
    end
    chk("sidle_rdy", {15'd0, bus.IN_READY}, 16'd0);
    for (int k = 0; k < 16; k++) begin
      step();
      chk_out($sformatf("skip%0d", k), (k < 4) ? K_COM : K_SKP, 1'b1, 2'(k % 4), 1'b0);
      chk($sformatf("skip_rdy%0d", k), {15'd0, bus.IN_READY}, 16'd0);
    end
    step();
    chk_out("skip_again", K_COM, 1'b1, 2'd0, 1'b0);

    rst = 1'b1;
    step();
    chk_reset("sreset");
    rst = 1'b0;

    // 12-byte packet spanning the expiry; END on lane 3 goes straight to SKIP.
    for (int i = 1; i <= 8; i++) begin
      step();
    end
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("sp_rdy%0d", i), {15'd0, bus.IN_READY}, 16'd1);
      if (i == 0) begin
        drive(1'b1, K_STP, 1'b1);
      end else if (i == 11) begin
        drive(1'b1, K_END, 1'b1);
      end else begin
        drive(1'b1, 8'(8'h10 + i), 1'b0);
      end
      step();
      if (i == 0) begin
        chk_out("sp_stp", K_STP, 1'b1, 2'd0, 1'b0);
      end else if (i == 11) begin
        chk_out("sp_end", K_END, 1'b1, 2'd3, 1'b0);
      end else begin
        chk_out($sformatf("sp_d%0d", i), 8'(8'h10 + i), 1'b0, 2'(i % 4), 1'b0);
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_out($sformatf("sp_skip%0d", k), (k < 4) ? K_COM : K_SKP, 1'b1, 2'(k % 4), 1'b0);
      chk($sformatf("sp_skip_rdy%0d", k), {15'd0, bus.IN_READY}, 16'd0);
    end

    // Reset mid-SKIP.
    rst = 1'b1;
    step();
    chk_reset("skip_reset");
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
